// File: rtl/mem_wb_pkg.sv
// Shared writeback-select and load-size encodings plus default widths for the MEM/WB stage.
package mem_wb_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int REG_AW_DEF = 5;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_LOAD = 2'b01;
    localparam logic [1:0] WB_PC4  = 2'b10;
    localparam logic [1:0] WB_IMM  = 2'b11;

    localparam logic [1:0] LD_B = 2'b00;
    localparam logic [1:0] LD_H = 2'b01;
    localparam logic [1:0] LD_W = 2'b10;
endpackage

// File: rtl/load_align.sv
// Load lane select and sign/zero extension; purely combinational, no backpressure.
module load_align
    import mem_wb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] data_i,
    input  logic [1:0]        addr_lo_i,
    input  logic [1:0]        size_i,
    input  logic              uns_i,
    output logic [DATA_W-1:0] data_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = data_i[7:0];
        case (addr_lo_i)
            2'd1:    byte_v = data_i[15:8];
            2'd2:    byte_v = data_i[23:16];
            2'd3:    byte_v = data_i[31:24];
            default: byte_v = data_i[7:0];
        endcase
        // Halfword loads use only addr bit 1; misaligned bit 0 is ignored.
        half_v = addr_lo_i[1] ? data_i[31:16] : data_i[15:0];

        data_o = data_i;
        case (size_i)
            LD_B:    data_o = {{(DATA_W-8){~uns_i & byte_v[7]}}, byte_v};
            LD_H:    data_o = {{(DATA_W-16){~uns_i & half_v[15]}}, half_v};
            LD_W:    data_o = data_i;
            default: data_o = data_i;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB register + writeback mux: capture edge then one WB cycle; wb_stall holds the entry, flush kills it.
// Optional EX forwarding outputs under `WB_FWD_EN.
module mem_wb_stage
    import mem_wb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic              flush,
    input  logic              wb_stall,
    input  logic [DATA_W-1:0] mem_alu_res,
    input  logic [DATA_W-1:0] mem_pc4,
    input  logic [DATA_W-1:0] mem_imm,
    input  logic [1:0]        mem_wb_sel,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_reg_we,
    input  logic [1:0]        mem_ld_size,
    input  logic              mem_ld_uns,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              wb_valid,
    output logic [31:0]       retire_cnt
`ifdef WB_FWD_EN
    ,
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_rd,
    output logic [DATA_W-1:0] fwd_data
`endif
);

    logic              wb_valid_q, wb_valid_d;
    logic              first_q, first_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic [DATA_W-1:0] alu_q, alu_d;
    logic [DATA_W-1:0] pc4_q, pc4_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [1:0]        sel_q, sel_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [31:0]       retire_cnt_q, retire_cnt_d;

    logic              capture;
    logic              retire;
    logic [DATA_W-1:0] ld_src;
    logic [DATA_W-1:0] ld_ext;
    logic [DATA_W-1:0] wb_mux;

    always_comb begin
        capture = mem_valid && !wb_stall && !flush;
        retire  = wb_valid_q && !wb_stall && !flush;

        wb_valid_d = wb_valid_q;
        alu_d      = alu_q;
        pc4_d      = pc4_q;
        imm_d      = imm_q;
        sel_d      = sel_q;
        rd_d       = rd_q;
        we_d       = we_q;
        size_d     = size_q;
        uns_d      = uns_q;

        // RAM data is only valid in the first WB cycle, so snapshot it for stalls.
        hold_d       = first_q ? dmem_rdata : hold_q;
        first_d      = capture;
        retire_cnt_d = retire ? retire_cnt_q + 32'd1 : retire_cnt_q;

        if (flush) begin
            wb_valid_d = 1'b0;
        end else if (capture) begin
            wb_valid_d = 1'b1;
            alu_d      = mem_alu_res;
            pc4_d      = mem_pc4;
            imm_d      = mem_imm;
            sel_d      = mem_wb_sel;
            rd_d       = mem_rd;
            we_d       = mem_reg_we;
            size_d     = mem_ld_size;
            uns_d      = mem_ld_uns;
        end else if (retire) begin
            wb_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid_q   <= 1'b0;
            first_q      <= 1'b0;
            hold_q       <= '0;
            alu_q        <= '0;
            pc4_q        <= '0;
            imm_q        <= '0;
            sel_q        <= '0;
            rd_q         <= '0;
            we_q         <= 1'b0;
            size_q       <= '0;
            uns_q        <= 1'b0;
            retire_cnt_q <= '0;
        end else begin
            wb_valid_q   <= wb_valid_d;
            first_q      <= first_d;
            hold_q       <= hold_d;
            alu_q        <= alu_d;
            pc4_q        <= pc4_d;
            imm_q        <= imm_d;
            sel_q        <= sel_d;
            rd_q         <= rd_d;
            we_q         <= we_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign ld_src = first_q ? dmem_rdata : hold_q;

    load_align #(
        .DATA_W(DATA_W)
    ) u_load_align (
        .data_i    (ld_src),
        .addr_lo_i (alu_q[1:0]),
        .size_i    (size_q),
        .uns_i     (uns_q),
        .data_o    (ld_ext)
    );

    always_comb begin
        wb_mux = imm_q;
        case (sel_q)
            WB_ALU:  wb_mux = alu_q;
            WB_LOAD: wb_mux = ld_ext;
            WB_PC4:  wb_mux = pc4_q;
            WB_IMM:  wb_mux = imm_q;
            default: wb_mux = imm_q;
        endcase
    end

    assign mem_ready  = !wb_stall;
    assign wb_valid   = wb_valid_q;
    assign retire_cnt = retire_cnt_q;
    assign rf_waddr   = rd_q;
    assign rf_wdata   = wb_valid_q ? wb_mux : '0;
    assign rf_we      = retire && we_q && (rd_q != '0);

`ifdef WB_FWD_EN
    assign fwd_valid = wb_valid_q && we_q && (rd_q != '0) && !flush;
    assign fwd_rd    = rd_q;
    assign fwd_data  = rf_wdata;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: constant load/mux vectors, hand corner sequences, random traffic vs. a reference model.
module tb_mem_wb_stage;

    logic        clk;
    logic        rst_n;
    logic        mem_valid;
    logic        mem_ready;
    logic        flush;
    logic        wb_stall;
    logic [31:0] mem_alu_res;
    logic [31:0] mem_pc4;
    logic [31:0] mem_imm;
    logic [1:0]  mem_wb_sel;
    logic [4:0]  mem_rd;
    logic        mem_reg_we;
    logic [1:0]  mem_ld_size;
    logic        mem_ld_uns;
    logic [31:0] dmem_rdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        wb_valid;
    logic [31:0] retire_cnt;
`ifdef WB_FWD_EN
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
`endif

    mem_wb_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_valid   (mem_valid),
        .mem_ready   (mem_ready),
        .flush       (flush),
        .wb_stall    (wb_stall),
        .mem_alu_res (mem_alu_res),
        .mem_pc4     (mem_pc4),
        .mem_imm     (mem_imm),
        .mem_wb_sel  (mem_wb_sel),
        .mem_rd      (mem_rd),
        .mem_reg_we  (mem_reg_we),
        .mem_ld_size (mem_ld_size),
        .mem_ld_uns  (mem_ld_uns),
        .dmem_rdata  (dmem_rdata),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .wb_valid    (wb_valid),
        .retire_cnt  (retire_cnt)
`ifdef WB_FWD_EN
        ,
        .fwd_valid   (fwd_valid),
        .fwd_rd      (fwd_rd),
        .fwd_data    (fwd_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;
    int n_writes = 0;

    // Reference model: one instruction slot, its captured load word, and a counter.
    typedef struct {
        logic [31:0] alu;
        logic [31:0] pc4;
        logic [31:0] imm;
        logic [1:0]  sel;
        logic [4:0]  rd;
        logic        we;
        logic [1:0]  size;
        logic        uns;
    } ent_t;

    ent_t        m_ent;
    logic        m_valid;
    logic        m_first;
    logic [31:0] m_word;
    logic [31:0] m_cnt;

    typedef struct {
        logic [31:0] alu;
        logic [1:0]  sel;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] dmem;
        logic [31:0] exp;
    } vec_t;

    vec_t vt[14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ld_model(input logic [31:0] w, input logic [1:0] lane,
                                             input logic [1:0] size, input logic uns);
        logic [31:0] v;
        if (size == 2'b00) begin
            v = (w >> (8 * int'(lane))) & 32'h0000_00FF;
            if (!uns && v[7]) v = v | 32'hFFFF_FF00;
        end else if (size == 2'b01) begin
            v = (w >> (16 * int'(lane[1]))) & 32'h0000_FFFF;
            if (!uns && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [31:0] wb_model(input ent_t e, input logic [31:0] w);
        case (e.sel)
            2'b00:   return e.alu;
            2'b01:   return ld_model(w, e.alu[1:0], e.size, e.uns);
            2'b10:   return e.pc4;
            default: return e.imm;
        endcase
    endfunction

    task automatic model_reset();
        m_ent   = '{default: '0};
        m_valid = 1'b0;
        m_first = 1'b0;
        m_word  = '0;
        m_cnt   = '0;
    endtask

    // Checks the current cycle against the model, advances the model, then crosses the clock edge.
    task automatic tick();
        logic [31:0] lw;
        logic [31:0] ew;
        logic        ret;
        logic        ewe;
        #1;
        lw  = m_first ? dmem_rdata : m_word;
        ew  = m_valid ? wb_model(m_ent, lw) : 32'h0;
        ret = m_valid && !wb_stall && !flush;
        ewe = ret && m_ent.we && (m_ent.rd != 5'd0);
        chk("mem_ready", 32'(mem_ready), 32'(!wb_stall));
        chk("wb_valid", 32'(wb_valid), 32'(m_valid));
        chk("rf_we", 32'(rf_we), 32'(ewe));
        chk("rf_wdata", rf_wdata, ew);
        if (m_valid) chk("rf_waddr", 32'(rf_waddr), 32'(m_ent.rd));
        chk("retire_cnt", retire_cnt, m_cnt);
`ifdef WB_FWD_EN
        chk("fwd_valid", 32'(fwd_valid), 32'(m_valid && m_ent.we && m_ent.rd != 5'd0 && !flush));
        chk("fwd_data", fwd_data, ew);
`endif
        if (rf_we) n_writes++;

        if (m_first) m_word = dmem_rdata;
        if (ret) m_cnt = m_cnt + 32'd1;
        if (flush) begin
            m_valid = 1'b0;
            m_first = 1'b0;
        end else if (mem_valid && !wb_stall) begin
            m_ent   = '{alu: mem_alu_res, pc4: mem_pc4, imm: mem_imm, sel: mem_wb_sel,
                        rd: mem_rd, we: mem_reg_we, size: mem_ld_size, uns: mem_ld_uns};
            m_valid = 1'b1;
            m_first = 1'b1;
        end else begin
            if (ret) m_valid = 1'b0;
            m_first = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mem_valid   = 1'b0;
        flush       = 1'b0;
        wb_stall    = 1'b0;
        mem_alu_res = '0;
        mem_pc4     = '0;
        mem_imm     = '0;
        mem_wb_sel  = 2'b00;
        mem_rd      = '0;
        mem_reg_we  = 1'b0;
        mem_ld_size = 2'b00;
        mem_ld_uns  = 1'b0;
        dmem_rdata  = '0;
    endtask

    task automatic present(input logic [31:0] alu, input logic [1:0] sel, input logic [4:0] rd,
                           input logic we, input logic [1:0] size, input logic uns);
        mem_valid   = 1'b1;
        mem_alu_res = alu;
        mem_wb_sel  = sel;
        mem_rd      = rd;
        mem_reg_we  = we;
        mem_ld_size = size;
        mem_ld_uns  = uns;
    endtask

    logic [31:0] cnt_before;

    initial begin
        vt[0]  = '{32'h13, 2'b01, 2'b00, 1'b0, 32'h80FF7F01, 32'hFFFFFF80};
        vt[1]  = '{32'h13, 2'b01, 2'b00, 1'b1, 32'h80FF7F01, 32'h00000080};
        vt[2]  = '{32'h10, 2'b01, 2'b00, 1'b0, 32'h80FF7F01, 32'h00000001};
        vt[3]  = '{32'h11, 2'b01, 2'b00, 1'b0, 32'h80FF7F01, 32'h0000007F};
        vt[4]  = '{32'h12, 2'b01, 2'b00, 1'b0, 32'h80FF7F01, 32'hFFFFFFFF};
        vt[5]  = '{32'h12, 2'b01, 2'b00, 1'b1, 32'h80FF7F01, 32'h000000FF};
        vt[6]  = '{32'h22, 2'b01, 2'b01, 1'b0, 32'h8001ABCD, 32'hFFFF8001};
        vt[7]  = '{32'h21, 2'b01, 2'b01, 1'b0, 32'h8001ABCD, 32'hFFFFABCD};
        vt[8]  = '{32'h23, 2'b01, 2'b01, 1'b1, 32'h8001ABCD, 32'h00008001};
        vt[9]  = '{32'h21, 2'b01, 2'b11, 1'b0, 32'h8001ABCD, 32'h8001ABCD};
        vt[10] = '{32'h03, 2'b01, 2'b10, 1'b0, 32'h80FF7F01, 32'h80FF7F01};
        vt[11] = '{32'h11, 2'b00, 2'b00, 1'b0, 32'hDEADBEEF, 32'h00000011};
        vt[12] = '{32'h11, 2'b10, 2'b00, 1'b0, 32'hDEADBEEF, 32'h00000104};
        vt[13] = '{32'h11, 2'b11, 2'b00, 1'b0, 32'hDEADBEEF, 32'h12345000};

        idle_inputs();
        model_reset();
        rst_n = 1'b0;
        #1;
        chk("reset wb_valid", 32'(wb_valid), 32'h0);
        chk("reset rf_we", 32'(rf_we), 32'h0);
        chk("reset rf_wdata", rf_wdata, 32'h0);
        chk("reset retire_cnt", retire_cnt, 32'h0);
        mem_valid = 1'b1;
        mem_reg_we = 1'b1;
        mem_rd = 5'd9;
        @(posedge clk);
        #1;
        chk("reset hold rf_we", 32'(rf_we), 32'h0);
        chk("reset hold wb_valid", 32'(wb_valid), 32'h0);
        idle_inputs();
        rst_n = 1'b1;

        // Back-to-back ALU writes with no bubble.
        present(32'h11, 2'b00, 5'd3, 1'b1, 2'b00, 1'b0);
        tick();
        present(32'h22, 2'b00, 5'd4, 1'b1, 2'b00, 1'b0);
        #1;
        chk("b2b first we", 32'(rf_we), 32'h1);
        chk("b2b first data", rf_wdata, 32'h11);
        chk("b2b first addr", 32'(rf_waddr), 32'd3);
        tick();
        mem_valid = 1'b0;
        #1;
        chk("b2b second we", 32'(rf_we), 32'h1);
        chk("b2b second data", rf_wdata, 32'h22);
        chk("b2b second addr", 32'(rf_waddr), 32'd4);
        tick();
        chk("b2b retire_cnt", retire_cnt, 32'd2);
        chk("b2b drained", 32'(wb_valid), 32'h0);

        // Constant vectors: capture, then check the WB cycle with the RAM word present.
        mem_pc4 = 32'h104;
        mem_imm = 32'h12345000;
        for (int i = 0; i < 14; i++) begin
            present(vt[i].alu, vt[i].sel, 5'd7, 1'b1, vt[i].size, vt[i].uns);
            tick();
            mem_valid  = 1'b0;
            dmem_rdata = vt[i].dmem;
            #1;
            chk($sformatf("vec%0d we", i), 32'(rf_we), 32'h1);
            chk($sformatf("vec%0d data", i), rf_wdata, vt[i].exp);
            tick();
        end

        // Half load held three cycles while RAM output goes to zero.
        n_writes = 0;
        present(32'h1002, 2'b01, 5'd8, 1'b1, 2'b01, 1'b0);
        tick();
        mem_valid  = 1'b0;
        dmem_rdata = 32'h8001ABCD;
        wb_stall   = 1'b1;
        for (int s = 0; s < 3; s++) begin
            #1;
            chk($sformatf("stall%0d we", s), 32'(rf_we), 32'h0);
            chk($sformatf("stall%0d data", s), rf_wdata, 32'hFFFF8001);
            tick();
            dmem_rdata = 32'h0;
        end
        wb_stall = 1'b0;
        #1;
        chk("stall release we", 32'(rf_we), 32'h1);
        chk("stall release data", rf_wdata, 32'hFFFF8001);
        tick();
        tick();
        chk("stall single write", 32'(n_writes), 32'd1);

        // x0 destination: no write, still retires.
        cnt_before = retire_cnt;
        mem_pc4 = 32'h104;
        present(32'h0, 2'b10, 5'd0, 1'b1, 2'b00, 1'b0);
        tick();
        mem_valid = 1'b0;
        #1;
        chk("x0 we", 32'(rf_we), 32'h0);
        chk("x0 data", rf_wdata, 32'h104);
        tick();
        chk("x0 retire_cnt", retire_cnt, cnt_before + 32'd1);

        // Flush with an entry in WB and a new instruction arriving.
        cnt_before = retire_cnt;
        present(32'h55, 2'b00, 5'd5, 1'b1, 2'b00, 1'b0);
        tick();
        present(32'h66, 2'b00, 5'd6, 1'b1, 2'b00, 1'b0);
        flush = 1'b1;
        #1;
        chk("flush we", 32'(rf_we), 32'h0);
        tick();
        flush = 1'b0;
        mem_valid = 1'b0;
        #1;
        chk("flush wb_valid", 32'(wb_valid), 32'h0);
        chk("flush retire_cnt", retire_cnt, cnt_before);
        chk("flush dropped we", 32'(rf_we), 32'h0);
        tick();

        // Counter wrap.
        force dut.retire_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.retire_cnt_q;
        m_cnt = 32'hFFFF_FFFF;
        present(32'h77, 2'b00, 5'd2, 1'b0, 2'b00, 1'b0);
        tick();
        mem_valid = 1'b0;
        tick();
        chk("wrap retire_cnt", retire_cnt, 32'h0);

        // Reset in the middle of a stall.
        present(32'h99, 2'b00, 5'd9, 1'b1, 2'b00, 1'b0);
        tick();
        mem_valid = 1'b0;
        wb_stall  = 1'b1;
        tick();
        rst_n = 1'b0;
        #1;
        chk("midrst wb_valid", 32'(wb_valid), 32'h0);
        chk("midrst rf_we", 32'(rf_we), 32'h0);
        chk("midrst rf_wdata", rf_wdata, 32'h0);
        chk("midrst rf_waddr", 32'(rf_waddr), 32'h0);
        chk("midrst retire_cnt", retire_cnt, 32'h0);
        wb_stall = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst no write", 32'(rf_we), 32'h0);
        rst_n = 1'b1;
        model_reset();
        tick();

        // Random traffic against the model.
        for (int c = 0; c < 600; c++) begin
            mem_valid   = ($urandom_range(0, 2) != 0);
            flush       = ($urandom_range(0, 9) == 0);
            wb_stall    = ($urandom_range(0, 2) == 0);
            mem_alu_res = $urandom;
            mem_pc4     = $urandom;
            mem_imm     = $urandom;
            mem_wb_sel  = 2'($urandom_range(0, 3));
            mem_rd      = 5'($urandom_range(0, 3));
            mem_reg_we  = ($urandom_range(0, 3) != 0);
            mem_ld_size = 2'($urandom_range(0, 3));
            mem_ld_uns  = ($urandom_range(0, 1) != 0);
            dmem_rdata  = $urandom;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM/WB pipeline register and writeback datapath of the 32-bit pipelined RISC core.
- Sits between the memory stage and the register-file write port.
- Captures MEM-stage results and control, aligns and extends load data from the synchronous data RAM, and applies the 2-bit writeback-source select.
- Drives the register-file write port, keeps a retired-instruction counter, and holds its entry under hazard stalls.

Parameters:
- DATA_W, 32, datapath width.
- REG_AW, 5, register address width.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- mem_valid  in  1  MEM stage presents an instruction.
- mem_ready  out  1  stage accepts this cycle.
- flush  in  1  kill the captured and incoming entry.
- wb_stall  in  1  hazard unit holds WB.
- mem_alu_res  in  DATA_W  ALU result; its low 2 bits are the load byte address.
- mem_pc4  in  DATA_W  PC+4.
- mem_imm  in  DATA_W  immediate for LUI-type ops.
- mem_wb_sel  in  2  writeback source: 00 ALU, 01 load, 10 PC+4, 11 imm.
- mem_rd  in  REG_AW  destination register.
- mem_reg_we  in  1  instruction writes rd.
- mem_ld_size  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- mem_ld_uns  in  1  zero-extend the load.
- dmem_rdata  in  DATA_W  sync RAM read data, valid in the first cycle an entry is in WB.
- rf_we  out  1  register-file write strobe.
- rf_waddr  out  REG_AW  write address.
- rf_wdata  out  DATA_W  write data.
- wb_valid  out  1  entry held in WB.
- retire_cnt  out  32  count of retired instructions.

Behaviour:
- Reset (async, rst_n=0): wb_valid=0, retire_cnt=0, load hold register=0, all captured fields=0, first flag=0. rf_we=0 throughout reset.
- mem_ready = !wb_stall.
- Capture occurs on mem_valid && mem_ready. All mem_* fields are latched and wb_valid is set next cycle.
- The first flag is set on capture. Whenever first=1, dmem_rdata is latched into the load hold register next cycle and first is cleared.
- Load source for the writeback mux:
  - first=1: dmem_rdata, combinationally.
  - first=0: the load hold register.
  - This keeps load data correct under a multi-cycle stall while the RAM output changes.
- Retire = wb_valid && !wb_stall.
- rf_we = retire && reg_we_q && (rd_q != 0). Register x0 is never written.
- rf_waddr = rd_q.
- rf_wdata = mux(sel_q). It is driven whenever wb_valid=1 and is 0 when wb_valid=0.
- Load extension, using lane = alu_q[1:0]:
  - byte: selects byte alu_q[1:0].
  - half: selects half alu_q[1]; alu_q[0] is ignored.
  - word: ignores the address.
  - Sign or zero extension follows mem_ld_uns.
- Each entry writes exactly once. During a stall, rf_we=0 and all fields hold.
- Retire with no new capture: wb_valid clears.
- Retire with a simultaneous capture: the new entry replaces the old one back-to-back with no bubble.
- retire_cnt increments by 1 on every retire, including instructions with reg_we=0, and wraps from 0xFFFFFFFF to 0.
- Flush has priority over both capture and stall:
  - Next cycle: wb_valid=0 and first=0.
  - Same cycle: rf_we is forced to 0 and retire_cnt does not count.
  - An incoming mem_valid in the flush cycle is dropped.
- Reset asserted mid-stall discards the entry immediately; no write occurs.
- Latency: capture edge, then one WB cycle with the write; zero added cycles when wb_stall=0.

Optional Feature:
- Macro WB_FWD_EN.
- When defined, adds outputs:
  - fwd_valid  out  1  = wb_valid && reg_we_q && rd_q!=0 && !flush.
  - fwd_rd  out  REG_AW  = rd_q.
  - fwd_data  out  DATA_W  = rf_wdata, same value.
  - These feed the EX-stage forwarding mux.
- When not defined, the ports are absent and the hazard unit must stall instead of forwarding.

Decomposition:
- Shared package holds:
  - writeback-select constants WB_ALU=2'b00, WB_LOAD=2'b01, WB_PC4=2'b10, WB_IMM=2'b11.
  - load-size constants LD_B, LD_H, LD_W.
  - the DATA_W and REG_AW defaults.
- One sub-module, load_align: combinational lane select plus sign/zero extension, taking (data, addr_lo, size, uns).
- The existing 4:1 writeback mux is reused per bit or as a vector for source selection.

Test Plan:
- Back-to-back ALU ops: rd=3 then rd=4, results 0x11 and 0x22, sel=00, no stall → rf_we high two consecutive cycles with data 0x11 then 0x22; retire_cnt=2.
- Signed byte load: dmem_rdata=0x80FF7F01, alu_res low bits=2'b11 → rf_wdata=0xFFFFFF80. Repeat with mem_ld_uns=1 → 0x00000080.
- Half load at alu_res low bits=2'b10, dmem_rdata=0x8001ABCD, signed → 0xFFFF8001. Hold wb_stall for 3 cycles while dmem_rdata changes to 0 → single write of 0xFFFF8001 after the stall releases.
- rd=0 with reg_we=1, sel=10, pc4=0x104 → rf_we stays 0; retire_cnt still increments.
- Flush asserted with an entry in WB and mem_valid=1 → no rf_we; wb_valid=0 next cycle; retire_cnt unchanged.
- Preload retire_cnt near wrap (via 0xFFFFFFFF retires or force) → next retire gives 0. rst_n pulsed low mid-stall → all outputs 0 asynchronously; no write.
